regfile: RTL and testbench
==========================

# regfile

General-purpose register file for the single-cycle MIPS datapath; it sits directly upstream of the ALU. Two combinational read ports supply ALU operand `a` (rs) and the rt value for operand `b` / store data. One synchronous write port takes the write-back value: the ALU result `s` or memory load data. Register 0 is hardwired to zero. An optional write-to-read bypass makes a same-cycle write visible on the read ports.

## Interface
Parameters:
- `DATA_W`, 32, register and port data width.
- `ADDR_W`, 5, register index width; depth is 2^ADDR_W.
- `BYPASS`, 1, 1 = read ports return `d` when reading the register being written this cycle; 0 = read ports return the stored value.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all registers.
- `rna`  in  ADDR_W  read port A index (rs).
- `rnb`  in  ADDR_W  read port B index (rt).
- `qa`  out  DATA_W  read port A data, to ALU `a`.
- `qb`  out  DATA_W  read port B data, to ALU `b` mux / store data.
- `we`  in  1  write enable.
- `wn`  in  ADDR_W  write index (rd or rt, chosen by control).
- `d`  in  DATA_W  write data: ALU `s` or load data.
- `dbg_rn`  in  ADDR_W  debug read index.
- `dbg_q`  out  DATA_W  debug read data; never bypassed.

Clock and reset: one clock (`clock`); `reset` is asynchronous and active-high.

## Operation
- Storage: registers 1..2^ADDR_W-1, each DATA_W flops. Register 0 has no storage.
- Write:
  - On the rising `clock` edge, if `we`=1 and `wn`≠0, `d` is stored into register `wn`.
  - `wn`=0 with `we`=1 is a silent no-op.
  - `we`=0 leaves every register unchanged.
- Read:
  - `qa`/`qb`/`dbg_q` are purely combinational in their index.
  - Index 0 always yields 0, regardless of `we`/`wn`/`d`.
- Bypass (`BYPASS`=1):
  - `qa` = `d` when `we`=1, `wn`=`rna` and `rna`≠0. Same rule for `qb` with `rnb`.
  - Both ports may bypass simultaneously.
  - `dbg_q` always shows the stored value.
- `BYPASS`=0: ports show the stored value; the new value appears after the edge.
- Reset:
  - `reset`=1 immediately (asynchronously) forces every stored register to 0. All outputs read 0 while reset is held.
  - While `reset`=1, writes are ignored, and bypass is suppressed (`qa`=`qb`=0).
  - A write whose edge coincides with reset assertion is lost.
  - After deassertion, the first write takes effect on the first rising edge with `reset`=0.
- Width rule: no sign or zero extension. Data passes through bit-exact.

## Timing
- Read latency: 0 cycles (combinational from `rna`/`rnb`/`dbg_rn`, plus `we`/`wn`/`d` when bypassing).
- Write latency: 1 edge. The value is readable from storage in the cycle after the write edge.
- The single-cycle CPU critical path is `rna` → `qa` → ALU → `d` → bypass mux. With `BYPASS`=1 this is a combinational loop whenever `wn`=`rna`. The top level sets `BYPASS`=0 for the single-cycle core. `BYPASS`=1 is reserved for the pipelined core, where `d` comes from the WB stage.
- Outputs after reset: `qa`=`qb`=`dbg_q`=0 for every index.
- Simultaneous write to register k and read of k, with `BYPASS`=0: the old value is returned in that cycle and the new value in the next.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W`=32, `ADDR_W`=5, `REG_ZERO`=5'd0.
  - Named indices `REG_SP`=29 and `REG_RA`=31, used by control for `jal`.
- Sub-module `regfile_rdport`:
  - Index-0 masking plus the optional bypass mux.
  - Instantiated for A and B, with bypass enabled per `BYPASS`.
  - The debug port uses the same sub-module with bypass tied off.
- Storage is a flop array with async clear. No memory macro, since async clear of all entries is required.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, then assert `reset` mid-cycle → `qa`(rna=5)=0 immediately, before any clock edge, and stays 0 after release.
- Zero register: `we`=1, `wn`=0, `d`=0xFFFFFFFF, edge → `qa`(rna=0)=0. With `BYPASS`=1, rna=0 also gives `qa`=0 during the write.
- Write/read all: write r1..r31 with value 0x1000_0000+k → each reads back exactly, on `qa`, `qb` and `dbg_q`. `we`=0 cycles change nothing.
- Same-cycle hazard, `BYPASS`=0: r7=0x11, then write 0x22 to r7 while rna=rnb=7 → 0x11 before the edge, 0x22 after.
- Same-cycle hazard, `BYPASS`=1, same stimulus → `qa`=`qb`=0x22 before the edge, `dbg_q`(7)=0x11 before the edge.
- ALU chain: r1=0x00000003, r2=0xFFFFFFF0, rna=1, rnb=2 into the ALU with SUB, write `s` to r3 → r3=0x00000013. ALU `z`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, register index width, named registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] regidx_t;

   // Architectural register indices used by control
   localparam regidx_t REG_ZERO = 5'd0;
   localparam regidx_t REG_SP   = 5'd29;
   localparam regidx_t REG_RA   = 5'd31;   // link register written by jal

endpackage

// File: rtl/regfile_rdport.sv
// Register file read port: forces index 0 to zero, optional write-to-read bypass.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the output follows the inputs every cycle.
//
// Ports:
//   rn      read index
//   stored  value currently held in storage for rn
//   reset   active-high reset; suppresses the bypass path
//   we/wn/d write port of the same cycle, used only when BYPASS != 0
//   q       read data
module regfile_rdport #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int BYPASS = 0
) (
   input  logic [ADDR_W-1:0] rn,
   input  logic [DATA_W-1:0] stored,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wn,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   import cpu_pkg::*;

   logic is_zero;
   logic bypass_hit;

   assign is_zero = (rn == ADDR_W'(REG_ZERO));

   // A write that the storage would drop (reset held, or index 0) must not
   // leak onto the read port either, so the same qualifiers apply here.
   assign bypass_hit = (BYPASS != 0) && !reset && we && (wn == rn) && !is_zero;

   always_comb begin
      q = '0;
      if (!is_zero) begin
         q = bypass_hit ? d : stored;
      end
   end

endmodule

// File: rtl/regfile.sv
// MIPS general-purpose register file: two operand read ports, one debug read port, one write port.
// Latency: reads 0 cycles (combinational); writes land on the next rising clock edge.
// Backpressure: none; a write with we=1 is always accepted unless reset is high or wn=0.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-high clear of every register
//   rna/qa      read port A (rs) -> ALU operand a
//   rnb/qb      read port B (rt) -> ALU operand b mux / store data
//   we/wn/d     write port (write-back of ALU result or load data)
//   dbg_rn/dbg_q debug read port, always shows stored contents
module regfile #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int BYPASS = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rna,
   input  logic [ADDR_W-1:0] rnb,
   output logic [DATA_W-1:0] qa,
   output logic [DATA_W-1:0] qb,
   input  logic              we,
   input  logic [ADDR_W-1:0] wn,
   input  logic [DATA_W-1:0] d,
   input  logic [ADDR_W-1:0] dbg_rn,
   output logic [DATA_W-1:0] dbg_q
);

   localparam int DEPTH = 1 << ADDR_W;

   // Flattened view of storage for the read muxes. Entry 0 has no flops;
   // it is a constant so the mux stays uniform.
   logic [DATA_W-1:0] regs [DEPTH];

   assign regs[0] = '0;

   // Discrete flops rather than a memory macro: every entry needs the async clear.
   for (genvar k = 1; k < DEPTH; k++) begin : g_reg
      logic [DATA_W-1:0] r;
      logic              hit;

      assign hit = we && (wn == ADDR_W'(k));

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r <= '0;
         end else if (hit) begin
            r <= d;
         end
      end

      assign regs[k] = r;
   end

   regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_rd_a (
      .rn     (rna),
      .stored (regs[rna]),
      .reset  (reset),
      .we     (we),
      .wn     (wn),
      .d      (d),
      .q      (qa)
   );

   regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_rd_b (
      .rn     (rnb),
      .stored (regs[rnb]),
      .reset  (reset),
      .we     (we),
      .wn     (wn),
      .d      (d),
      .q      (qb)
   );

   // Debug view never bypasses, so it always reflects architectural state.
   regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (0)
   ) u_rd_dbg (
      .rn     (dbg_rn),
      .stored (regs[dbg_rn]),
      .reset  (reset),
      .we     (1'b0),
      .wn     ('0),
      .d      ('0),
      .q      (dbg_q)
   );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: one instance without bypass, one with.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// A reference array of register contents is updated after each rising edge.
module tb_regfile;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int N  = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] rna, rnb, wn, dbg_rn;
   logic          we;
   logic [DW-1:0] d;
   logic [DW-1:0] qa0, qb0, dq0;
   logic [DW-1:0] qa1, qb1, dq1;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model [N];

   regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut0 (
      .clock(clock), .reset(reset), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
      .we(we), .wn(wn), .d(d), .dbg_rn(dbg_rn), .dbg_q(dq0)
   );

   regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut1 (
      .clock(clock), .reset(reset), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
      .we(we), .wn(wn), .d(d), .dbg_rn(dbg_rn), .dbg_q(dq1)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          we;
      logic [AW-1:0] wn;
      logic [DW-1:0] d;
      logic [AW-1:0] rna;
      logic [AW-1:0] rnb;
      logic [AW-1:0] dbg;
      logic [DW-1:0] e_qa0;
      logic [DW-1:0] e_qb0;
      logic [DW-1:0] e_qa1;
      logic [DW-1:0] e_qb1;
      logic [DW-1:0] e_dbg;
   } vec_t;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] stored_of(input logic [AW-1:0] i);
      if (i == 0) return '0;
      return model[i];
   endfunction

   function automatic logic [DW-1:0] bypassed_of(input logic [AW-1:0] i);
      if (!reset && we && (i == wn) && (i != 0)) return d;
      return stored_of(i);
   endfunction

   task automatic check_model(input string tag);
      chk({tag, ".qa0"}, qa0, stored_of(rna));
      chk({tag, ".qb0"}, qb0, stored_of(rnb));
      chk({tag, ".dbg0"}, dq0, stored_of(dbg_rn));
      chk({tag, ".qa1"}, qa1, bypassed_of(rna));
      chk({tag, ".qb1"}, qb1, bypassed_of(rnb));
      chk({tag, ".dbg1"}, dq1, stored_of(dbg_rn));
   endtask

   task automatic drive(input logic we_i, input logic [AW-1:0] wn_i, input logic [DW-1:0] d_i,
                        input logic [AW-1:0] rna_i, input logic [AW-1:0] rnb_i,
                        input logic [AW-1:0] dbg_i);
      @(negedge clock);
      we = we_i; wn = wn_i; d = d_i; rna = rna_i; rnb = rnb_i; dbg_rn = dbg_i;
      #1;
   endtask

   // Architectural effect of the upcoming rising edge
   task automatic commit();
      @(posedge clock);
      if (!reset && we && (wn != 0)) model[wn] = d;
   endtask

   function automatic void clear_model();
      for (int i = 0; i < N; i++) model[i] = '0;
   endfunction

   vec_t vecs [8];

   initial begin
      logic [DW-1:0] exp_k;

      vecs[0] = '{1'b1, 5'd7,  32'h11,        5'd7,  5'd7,  5'd7,  32'h0,  32'h0,  32'h11, 32'h11, 32'h0};
      vecs[1] = '{1'b1, 5'd7,  32'h22,        5'd7,  5'd7,  5'd7,  32'h11, 32'h11, 32'h22, 32'h22, 32'h11};
      vecs[2] = '{1'b0, 5'd7,  32'h33,        5'd7,  5'd7,  5'd7,  32'h22, 32'h22, 32'h22, 32'h22, 32'h22};
      vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF,  5'd0,  5'd7,  5'd0,  32'h0,  32'h22, 32'h0,  32'h22, 32'h0};
      vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  5'd0,  32'h0,  32'h0,  32'h0,  32'h0,  32'h0};
      vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5,  5'd31, 5'd7,  5'd31, 32'h0,  32'h22, 32'hA5A5A5A5, 32'h22, 32'h0};
      vecs[6] = '{1'b0, 5'd31, 32'h0,         5'd31, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[7] = '{1'b1, 5'd3,  32'h5A5A5A5A,  5'd3,  5'd31, 5'd3,  32'h0,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0};

      // ---- reset held from time 0: every index reads 0, writes and bypass suppressed
      reset = 1'b1; we = 1'b1; wn = 5'd5; d = 32'hDEADBEEF;
      rna = 5'd5; rnb = 5'd31; dbg_rn = 5'd5;
      clear_model();
      #2;
      check_model("rst_hold");
      commit();
      #1;
      check_model("rst_edge");
      @(negedge clock);
      reset = 1'b0; we = 1'b0;
      #1;
      chk("rst_rel.qa0", qa0, 32'h0);
      chk("rst_rel.dbg1", dq1, 32'h0);

      // ---- table-driven hazard / zero-register vectors
      foreach (vecs[i]) begin
         drive(vecs[i].we, vecs[i].wn, vecs[i].d, vecs[i].rna, vecs[i].rnb, vecs[i].dbg);
         chk($sformatf("vec%0d.qa0", i), qa0, vecs[i].e_qa0);
         chk($sformatf("vec%0d.qb0", i), qb0, vecs[i].e_qb0);
         chk($sformatf("vec%0d.qa1", i), qa1, vecs[i].e_qa1);
         chk($sformatf("vec%0d.qb1", i), qb1, vecs[i].e_qb1);
         chk($sformatf("vec%0d.dbg0", i), dq0, vecs[i].e_dbg);
         chk($sformatf("vec%0d.dbg1", i), dq1, vecs[i].e_dbg);
         commit();
      end

      // ---- write r1..r31, then read back with we=0 and junk on d
      for (int k = 1; k < N; k++) begin
         drive(1'b1, AW'(k), 32'h1000_0000 + DW'(k), '0, '0, '0);
         commit();
      end
      for (int k = 0; k < N; k++) begin
         exp_k = (k == 0) ? 32'h0 : 32'h1000_0000 + DW'(k);
         drive(1'b0, AW'(k), 32'hFFFF_FFFF, AW'(k), AW'(k), AW'(k));
         chk($sformatf("wall%0d.qa", k), qa0, exp_k);
         chk($sformatf("wall%0d.qb", k), qb1, exp_k);
         chk($sformatf("wall%0d.dbg", k), dq0, exp_k);
         commit();
      end

      // ---- ALU chain: r3 = r1 - r2 via the read ports
      drive(1'b1, 5'd1, 32'h0000_0003, '0, '0, '0); commit();
      drive(1'b1, 5'd2, 32'hFFFF_FFF0, '0, '0, '0); commit();
      @(negedge clock);
      we = 1'b1; wn = 5'd3; rna = 5'd1; rnb = 5'd2; dbg_rn = 5'd3;
      #1;
      d = qa0 - qb0;
      #1;
      check_model("alu_in");
      commit();
      drive(1'b0, 5'd0, '0, 5'd3, 5'd3, 5'd3);
      chk("alu_r3", qa0, 32'h0000_0013);
      chk("alu_z", {31'b0, (qa0 == 32'h0)}, 32'h0);
      commit();

      // ---- reset asserted mid-cycle clears storage before any edge
      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5); commit();
      drive(1'b0, 5'd5, '0, 5'd5, 5'd5, 5'd5);
      chk("mid_pre.qa0", qa0, 32'hDEADBEEF);
      #2;
      reset = 1'b1;
      clear_model();
      #1;
      chk("mid_rst.qa0", qa0, 32'h0);
      chk("mid_rst.qa1", qa1, 32'h0);
      check_model("mid_rst");
      drive(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5, 5'd5);
      chk("mid_byp.qa1", qa1, 32'h0);
      commit();
      @(negedge clock);
      reset = 1'b0; we = 1'b0;
      #1;
      chk("mid_rel.qa0", qa0, 32'h0);
      check_model("mid_rel");
      drive(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5, 5'd5); commit();
      drive(1'b0, 5'd0, '0, 5'd5, 5'd5, 5'd5);
      chk("mid_first.qa0", qa0, 32'h1234_5678);
      commit();

      // ---- randomized traffic against the reference array
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] w;
         w = AW'($urandom_range(0, N - 1));
         drive(1'($urandom_range(0, 1)), w, $urandom(),
               ($urandom_range(0, 2) == 0) ? w : AW'($urandom_range(0, N - 1)),
               ($urandom_range(0, 2) == 0) ? w : AW'($urandom_range(0, N - 1)),
               AW'($urandom_range(0, N - 1)));
         check_model($sformatf("rnd%0d", i));
         commit();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
